// File: rtl/gpio_pad_in_sync.sv
// Pad-to-core receive path: two-flop synchroniser, optional per-pin debounce
// (GPIO_DEBOUNCE_EN), edge/level event detection and sticky interrupt status.
module gpio_pad_in_sync #(
    parameter int NUM_GPIO   = 64,
    parameter int NUM_PADS   = 58,
    parameter int DEBOUNCE_W = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_GPIO-1:0]     pad_in_i,
    input  logic [NUM_GPIO-1:0]     in_en_i,
    input  logic [NUM_GPIO-1:0]     irq_en_i,
    input  logic [2*NUM_GPIO-1:0]   irq_type_i,
    input  logic [NUM_GPIO-1:0]     irq_clr_i,
    output logic [NUM_GPIO-1:0]     gpio_in_o,
    output logic [NUM_GPIO-1:0]     irq_status_o,
    output logic                    irq_o
`ifdef GPIO_DEBOUNCE_EN
    ,
    input  logic [DEBOUNCE_W-1:0]   debounce_cnt_i
`endif
);

    // Unbonded pins are tied low at the first synchroniser stage.
    localparam logic [NUM_GPIO-1:0] PAD_MASK = {NUM_GPIO{1'b1}} >> (NUM_GPIO - NUM_PADS);

    logic [NUM_GPIO-1:0] s1_q, s2_q;
    logic [NUM_GPIO-1:0] gpio_in_q, gpio_in_d;
    logic [NUM_GPIO-1:0] prev_q;
    logic [NUM_GPIO-1:0] status_q, status_d;
    logic [NUM_GPIO-1:0] stable;
    logic [NUM_GPIO-1:0] rise, fall, evt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= pad_in_i & PAD_MASK;
            s2_q <= s1_q & PAD_MASK;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam logic [DEBOUNCE_W-1:0] CNT_ONE = {{(DEBOUNCE_W-1){1'b0}}, 1'b1};

    logic [NUM_GPIO-1:0]   stable_q, stable_d;
    logic [DEBOUNCE_W-1:0] cnt_q [NUM_GPIO];
    logic [DEBOUNCE_W-1:0] cnt_d [NUM_GPIO];

    // Compare is one bit wider so counter+1 never wraps before the threshold test.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NUM_GPIO; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != stable_q[i]) begin
                if (({1'b0, cnt_q[i]} + {1'b0, CNT_ONE}) >= {1'b0, debounce_cnt_i}) begin
                    stable_d[i] = s2_q[i];
                end else if (cnt_q[i] != {DEBOUNCE_W{1'b1}}) begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end else begin
                    cnt_d[i] = cnt_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stable_q <= '0;
            for (int i = 0; i < NUM_GPIO; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            for (int i = 0; i < NUM_GPIO; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign stable = stable_q;
`else
    assign stable = s2_q;
`endif

    assign gpio_in_d = stable & in_en_i;
    assign rise      = gpio_in_q & ~prev_q;
    assign fall      = ~gpio_in_q & prev_q;

    always_comb begin
        evt = '0;
        for (int i = 0; i < NUM_GPIO; i++) begin
            case (irq_type_i[2*i +: 2])
                2'b00:   evt[i] = rise[i];
                2'b01:   evt[i] = fall[i];
                2'b10:   evt[i] = rise[i] | fall[i];
                default: evt[i] = gpio_in_q[i];
            endcase
        end
    end

    // A coincident clear and new event leaves the bit set.
    assign status_d = (status_q & ~irq_clr_i) | (irq_en_i & evt);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gpio_in_q <= '0;
            prev_q    <= '0;
            status_q  <= '0;
        end else begin
            gpio_in_q <= gpio_in_d;
            prev_q    <= gpio_in_q;
            status_q  <= status_d;
        end
    end

    assign gpio_in_o    = gpio_in_q;
    assign irq_status_o = status_q;
    assign irq_o        = |status_q;

endmodule

// File: tb/tb_gpio_pad_in_sync.sv
// Scoreboard bench for gpio_pad_in_sync: directed stimulus pushes timed
// expectations, a negedge monitor pops and compares them.
module tb_gpio_pad_in_sync;

    localparam int NG = 64;
`ifdef GPIO_DEBOUNCE_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    localparam logic [NG-1:0] ALL   = {NG{1'b1}};
    localparam logic [NG-1:0] UPPER = {6'h3F, 58'd0};
    localparam logic [NG-1:0] P3    = 64'd1 << 3;
    localparam logic [NG-1:0] P5    = 64'd1 << 5;
    localparam logic [NG-1:0] P12   = 64'd1 << 12;
    localparam logic [NG-1:0] P20   = 64'd1 << 20;
    localparam logic [NG-1:0] P40   = 64'd1 << 40;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NG-1:0]   pad, in_en, irq_en, clr;
    logic [2*NG-1:0] itype;
    logic [NG-1:0]   gpio_in, status;
    logic            irq;
`ifdef GPIO_DEBOUNCE_EN
    logic [7:0]      dbc;
`endif

    gpio_pad_in_sync dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .pad_in_i     (pad),
        .in_en_i      (in_en),
        .irq_en_i     (irq_en),
        .irq_type_i   (itype),
        .irq_clr_i    (clr),
        .gpio_in_o    (gpio_in),
        .irq_status_o (status),
        .irq_o        (irq)
`ifdef GPIO_DEBOUNCE_EN
        ,
        .debounce_cnt_i (dbc)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int            cyc;
        int            fld;
        logic [NG-1:0] mask;
        logic [NG-1:0] val;
        string         name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic exp_at(input int c, input int f, input logic [NG-1:0] m,
                          input logic [NG-1:0] v, input string n);
        exp_t e;
        e.cyc = c; e.fld = f; e.mask = m; e.val = v; e.name = n;
        sb.push_back(e);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // fld: 0 gpio_in_o, 1 irq_status_o, 2 irq_o
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                logic [NG-1:0] act;
                case (sb[i].fld)
                    0:       act = gpio_in;
                    1:       act = status;
                    default: act = {63'd0, irq};
                endcase
                checks++;
                if ((act & sb[i].mask) !== (sb[i].val & sb[i].mask)) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", sb[i].name, cyc,
                             act & sb[i].mask, sb[i].val & sb[i].mask);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout cyc=%0d expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, a, b, c, c0;
        rst_n  = 1'b0;
        pad    = ALL;
        in_en  = ALL;
        irq_en = '0;
        clr    = '0;
        itype  = '0;
`ifdef GPIO_DEBOUNCE_EN
        dbc    = 8'd1;
`endif
        tick(3);
        exp_at(3, 0, ALL, '0, "rst_gpio");
        exp_at(3, 1, ALL, '0, "rst_status");
        exp_at(3, 2, 1, 0, "rst_irq");
        rst_n = 1'b1;
        exp_at(5 + LAT, 0, ALL, '0, "rel_gpio_pre");
        exp_at(6 + LAT, 0, ALL, 64'h03FF_FFFF_FFFF_FFFF, "rel_gpio");
        exp_at(6 + LAT, 1, ALL, '0, "rel_status");
        tick(5);

        // unbonded pins: level-high type, enabled, pads driven high
        itype[127:116] = '1;
        irq_en[63:58]  = '1;
        n = cyc;
        exp_at(n + 5, 1, UPPER, '0, "unbonded_status");
        exp_at(n + 5, 0, UPPER, '0, "unbonded_gpio");
        tick(6);
        irq_en = '0;
        itype  = '0;
        pad    = '0;
        tick(6 + LAT);

        // rising edge on pin 5
        irq_en[5] = 1'b1;
        tick();
        n = cyc;
        pad[5] = 1'b1;
        exp_at(n + 2 + LAT, 0, P5, '0, "rise_gpio_pre");
        exp_at(n + 3 + LAT, 0, P5, P5, "rise_gpio");
        exp_at(n + 3 + LAT, 1, P5, '0, "rise_stat_pre");
        exp_at(n + 4 + LAT, 1, ALL, P5, "rise_stat");
        exp_at(n + 4 + LAT, 2, 1, 1, "rise_irq");
        tick(6 + LAT);
        clr[5] = 1'b1;
        tick();
        clr = '0;
        exp_at(cyc, 1, ALL, '0, "rise_clr");
        n = cyc;
        pad[5] = 1'b0;
        exp_at(n + 3 + LAT, 0, P5, '0, "fall_gpio");
        exp_at(n + 4 + LAT, 1, P5, '0, "fall_nostat");
        exp_at(n + 6 + LAT, 2, 1, 0, "fall_noirq");
        tick(7 + LAT);
        irq_en[5] = 1'b0;

        // both edges on pin 12, clear coinciding with the second set
        itype[25:24] = 2'b10;
        irq_en[12]   = 1'b1;
        tick();
        a = cyc;
        pad[12] = 1'b1;
        exp_at(a + 4 + LAT, 1, P12, P12, "both_set1");
        tick(6 + LAT);
        clr[12] = 1'b1;
        tick();
        clr = '0;
        exp_at(a + 7 + LAT, 1, P12, '0, "both_clr1");
        tick(a + 10 - cyc);
        pad[12] = 1'b0;
        exp_at(a + 13 + LAT, 1, P12, '0, "both_pre2");
        exp_at(a + 14 + LAT, 1, P12, P12, "both_set2_clr");
        exp_at(a + 16 + LAT, 1, P12, P12, "both_hold");
        tick(3 + LAT);
        clr[12] = 1'b1;
        tick();
        clr = '0;
        tick(3);
        clr[12] = 1'b1;
        tick();
        clr = '0;
        exp_at(cyc, 1, P12, '0, "both_clr2");
        irq_en[12]   = 1'b0;
        itype[25:24] = 2'b00;

        // level-high on pin 40
        itype[81:80] = 2'b11;
        irq_en[40]   = 1'b1;
        b = cyc;
        pad[40] = 1'b1;
        exp_at(b + 3 + LAT, 1, P40, '0, "lvl_pre");
        exp_at(b + 4 + LAT, 1, P40, P40, "lvl_set");
        exp_at(b + 4 + LAT, 2, 1, 1, "lvl_irq");
        tick(6 + LAT);
        clr[40] = 1'b1;
        tick();
        clr = '0;
        exp_at(cyc, 1, P40, P40, "lvl_reassert");
        exp_at(cyc + 1, 1, P40, P40, "lvl_reassert2");
        c0 = cyc;
        pad[40] = 1'b0;
        tick(4 + LAT);
        exp_at(cyc + 1, 1, P40, '0, "lvl_clr");
        exp_at(cyc + 3, 1, P40, '0, "lvl_stay0");
        clr[40] = 1'b1;
        tick();
        clr = '0;
        tick(3);
        irq_en[40]   = 1'b0;
        itype[81:80] = 2'b00;

        // input enable raised on a high pad, pin 20
        in_en[20] = 1'b0;
        pad[20]   = 1'b1;
        tick(6 + LAT);
        irq_en[20] = 1'b1;
        tick();
        c = cyc;
        in_en[20] = 1'b1;
        exp_at(c, 0, P20, '0, "en_gpio_pre");
        exp_at(c + 1, 0, P20, P20, "en_gpio");
        exp_at(c + 1, 1, P20, '0, "en_stat_pre");
        exp_at(c + 2, 1, P20, P20, "en_stat");
        tick(3);
        irq_en[20] = 1'b0;
        exp_at(cyc + 3, 1, P20, P20, "en_dis_keep");
        tick(4);

`ifdef GPIO_DEBOUNCE_EN
        // threshold 4: short glitch filtered, long pulse accepted
        dbc = 8'd4;
        tick();
        n = cyc;
        pad[3] = 1'b1;
        for (int k = 1; k <= 10; k++) exp_at(n + k, 0, P3, '0, "db_glitch");
        tick(2);
        pad[3] = 1'b0;
        tick(10);
        n = cyc;
        pad[3] = 1'b1;
        exp_at(n + 6, 0, P3, '0, "db_pre");
        exp_at(n + 7, 0, P3, P3, "db_rise");
        tick(6);
        pad[3] = 1'b0;
        tick(10);
`endif

        tick(5);
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
            errors += sb.size();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_pad_in_sync.md
Name: gpio_pad_in_sync

Overview:
Pad-to-core receive path for the 64-bit APB GPIO. It takes raw asynchronous pad input levels from the padframe, synchronises them into clk_i (with optional debounce), and drives the controller's gpio_in vector. It also detects per-pin edge/level events and keeps sticky interrupt status with a single OR-reduced interrupt line. Sits between the padframe input side and the GPIO register file.

Parameters:
NUM_GPIO, 64, width of every per-pin vector
NUM_PADS, 58, pins [NUM_PADS-1:0] are bonded to pads; pins at or above NUM_PADS read constant 0 and never raise events
DEBOUNCE_W, 8, width of debounce counters and threshold (used only with GPIO_DEBOUNCE_EN)

Ports:
clk_i  in  1  peripheral clock
rst_ni  in  1  asynchronous active-low reset
pad_in_i  in  NUM_GPIO  raw pad input levels, asynchronous to clk_i
in_en_i  in  NUM_GPIO  per-pin input enable; 0 forces that pin's filtered value to 0
irq_en_i  in  NUM_GPIO  per-pin interrupt enable
irq_type_i  in  2*NUM_GPIO  per-pin {bit 2i+1, bit 2i}: 00 rising, 01 falling, 10 both edges, 11 level-high
irq_clr_i  in  NUM_GPIO  one-cycle clear pulse for irq_status_o bits
gpio_in_o  out  NUM_GPIO  synchronised (optionally debounced) pin values to the GPIO controller
irq_status_o  out  NUM_GPIO  sticky per-pin interrupt status
irq_o  out  1  OR of irq_status_o
debounce_cnt_i  in  DEBOUNCE_W  debounce threshold in clk_i cycles (present only with GPIO_DEBOUNCE_EN)

Behaviour:
- Reset (rst_ni low, async): all synchroniser flops, gpio_in_o, edge-history register, irq_status_o and debounce counters clear to 0; irq_o = 0. Deassertion is taken synchronously by the integrating reset synchroniser and is not handled here.
- Synchroniser: two flops per pin, s1 <= pad_in_i, s2 <= s1. Pins >= NUM_PADS: s1/s2 held at 0.
- Filtered value f = s2 & in_en_i, registered into gpio_in_o. Pad change set up before edge k appears on gpio_in_o after edge k+2, i.e. 3-cycle latency without debounce.
- Edge history: prev <= gpio_in_o every cycle. rise = gpio_in_o & ~prev; fall = ~gpio_in_o & prev.
- Event per pin by type: 00 rise, 01 fall, 10 rise|fall, 11 gpio_in_o (asserted every cycle while high).
- Status: irq_status_o[i] <= (irq_status_o[i] & ~irq_clr_i[i]) | (irq_en_i[i] & event[i]). If set and clear coincide, set wins. Level-high pins re-set on the cycle after a clear while still high.
- irq_en_i low blocks new events and does not clear existing status. A change on irq_type_i or irq_en_i takes effect the same cycle and never by itself creates an event.
- Raising in_en_i on a pin whose pad is high yields a rising edge on gpio_in_o one cycle later. This is a real event and is reported if enabled. Lowering in_en_i yields a falling edge.
- irq_o is combinational OR of irq_status_o. No combinational path from pad_in_i to any output.

Optional Feature:
GPIO_DEBOUNCE_EN
- Defined: debounce_cnt_i port exists. A per-pin DEBOUNCE_W counter sits between s2 and the in_en gate.
  - If s2 == current stable value, counter <= 0.
  - Else counter increments. When counter+1 >= debounce_cnt_i, stable <= s2 and counter <= 0.
  - debounce_cnt_i of 0 or 1 accepts a change after 1 cycle, adding 1 cycle of latency.
  - A glitch shorter than the threshold never reaches gpio_in_o.
  - Lowering the threshold mid-count takes effect immediately via the >= compare. The counter saturates at all-ones.
- Undefined: no port, no counters; stable = s2 directly. Latency as stated in Behaviour.

Test Plan:
- Reset: pad_in_i=all 1s, rst_ni low -> gpio_in_o=0, irq_status_o=0, irq_o=0. Release with in_en_i=all 1s -> gpio_in_o=0x03FF_FFFF_FFFF_FFFF after 3 cycles; pins 58-63 stay 0.
- Rising edge: pin 5, type 00, irq_en=1, pad 0->1 before edge k -> gpio_in_o[5]=1 after k+2, irq_status_o[5]=1 and irq_o=1 after k+3. Pad 1->0 sets nothing.
- Both edges plus clear: pin 12, type 10. Toggle pad 0->1->0 with 10-cycle spacing -> two status sets. irq_clr_i[12] pulsed on the same cycle as the second set -> status stays 1.
- Level type: pin 40, type 11, pad held high, clear pulsed -> status 1 again next cycle. Drop pad, wait 3 cycles, clear -> status stays 0.
- Enable gating: pad 20 high, in_en_i[20] 0->1, type 00, irq_en=1 -> gpio_in_o[20] rises next cycle and status sets. irq_en_i deassert afterwards leaves status 1.
- Debounce (GPIO_DEBOUNCE_EN, cnt=4): a 2-cycle pulse on pad 3 -> gpio_in_o[3] never changes. A 6-cycle pulse -> gpio_in_o[3] rises 3+4 cycles after the pad edge.
